pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer: owns the PC register; computes
//  PC+4 and the branch/jump target (PC+4 + sign-extended word offset) on a
//  dedicated adder. Selects the next PC and holds it while the memory hierarchy
//  stalls. A taken redirect that arrives during a stall is buffered, not lost.
//  Sits between the control unit/ALU flags and the instruction cache address.
// PARAMETERS
//  PC_W      32   PC and address width in bits
//  OFF_W     8    signed instruction-word offset width (OFF_W < PC_W-2)
//  RESET_PC  0    PC value loaded on reset (PC_W bits, word aligned)
// PORTS
//  CLK              in   1        clock, rising edge
//  RESET            in   1        asynchronous, active-high reset
//  BUSYWAIT         in   1        memory stall; PC must hold while 1
//  JUMP             in   1        unconditional redirect
//  BRANCH_EQ        in   1        redirect if ZERO=1
//  BRANCH_NE        in   1        redirect if ZERO=0
//  ZERO             in   1        ALU zero flag
//  OFFSET           in   OFF_W    signed word offset from the instruction
//  PC               out  PC_W     current fetch address (registered)
//  PC_PLUS4         out  PC_W     PC+4, combinational
//  TARGET           out  PC_W     PC_PLUS4 + {sext(OFFSET),2'b00}, combinational
//  FETCH_VALID      out  1        1 when PC is a valid fetch address (registered)
//  REDIRECT_PENDING out  1        1 while a buffered redirect waits (registered)
//  WRAP_FLAG        out  1        only with PC_WRAP_CHK_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset (async, any time): PC=RESET_PC, FETCH_VALID=0, REDIRECT_PENDING=0,
//    saved target=0, WRAP_FLAG=0, state=BOOT. A pending redirect is discarded.
//  - take = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO). It is evaluated
//    only in RUN. BRANCH_EQ and BRANCH_NE asserted together is legal; it ORs.
//  - Arithmetic: all modulo 2^PC_W. OFFSET is sign-extended to PC_W-2 bits and
//    then shifted left 2. Wrap past 0 or 2^PC_W is silent without the macro.
//  - States:
//    BOOT: first rising edge after RESET falls -> RUN, FETCH_VALID<=1, PC held.
//    RUN,  BUSYWAIT=0: PC<=take ? TARGET : PC_PLUS4.
//    RUN,  BUSYWAIT=1, take=0: PC held, stay RUN.
//    RUN,  BUSYWAIT=1, take=1: PC held, saved<=TARGET, REDIRECT_PENDING<=1
//          -> HOLD_REDIR.
//    HOLD_REDIR, BUSYWAIT=1: PC held. All new JUMP/BRANCH inputs are ignored;
//          the first redirect wins.
//    HOLD_REDIR, BUSYWAIT=0: PC<=saved, REDIRECT_PENDING<=0 -> RUN. The saved
//          target takes precedence over any take asserted in the same cycle.
//  - Latency: the new PC is visible 1 cycle after the deciding edge. PC_PLUS4
//    and TARGET follow PC combinationally within the same cycle.
//  - FETCH_VALID stays 1 from BOOT exit until the next reset. The BUSYWAIT
//    hold does not clear it.
// CONFIGURATION
//  PC_WRAP_CHK_EN defined: WRAP_FLAG is a registered sticky flag. It is set on
//    any PC update where PC_PLUS4 or the selected TARGET wrapped modulo
//    2^PC_W, and it is cleared only by RESET. PC still wraps.
//  PC_WRAP_CHK_EN undefined: the WRAP_FLAG port and its logic are absent.
// TESTING
//  1 RESET pulse mid-stall with redirect pending -> PC=RESET_PC, PENDING=0,
//    FETCH_VALID=0. After release, 1 BOOT cycle, then PC=0,4,8.
//  2 PC=0x10, BRANCH_EQ=1, ZERO=1, OFFSET=8'hFE, BUSYWAIT=0 -> next PC=0x0C.
//    With ZERO=0 -> next PC=0x14.
//  3 PC=0x20, JUMP=1, OFFSET=8'h05, BUSYWAIT=1 for 3 cycles -> PC holds 0x20,
//    PENDING=1. On the 1st edge with BUSYWAIT=0 -> PC=0x38, PENDING=0.
//  4 In HOLD_REDIR (saved=0x38), JUMP again with OFFSET=8'h7F, then BUSYWAIT
//    falls -> PC=0x38. The second redirect is ignored.
//  5 BUSYWAIT=1, no take, 5 cycles -> PC constant, FETCH_VALID=1, PENDING=0.
//  6 PC_WRAP_CHK_EN, PC_W=8: PC=0xFC, no take -> PC=0x00, WRAP_FLAG=1 and it
//    stays 1 until RESET. Without the macro: PC=0x00, no flag.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-address bundle between the control unit / ALU flags and the PC sequencer.
// The wrap_flag signal exists only when PC_WRAP_CHK_EN is defined.
interface pc_sequencer_if #(
    parameter int PC_W  = 32,
    parameter int OFF_W = 8
);
    logic             busywait;
    logic             jump;
    logic             branch_eq;
    logic             branch_ne;
    logic             zero;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_plus4;
    logic [PC_W-1:0]  target;
    logic             fetch_valid;
    logic             redirect_pending;
`ifdef PC_WRAP_CHK_EN
    logic             wrap_flag;
`endif

    modport master (
        output busywait, jump, branch_eq, branch_ne, zero, offset,
        input  pc, pc_plus4, target, fetch_valid, redirect_pending
`ifdef PC_WRAP_CHK_EN
        , input wrap_flag
`endif
    );

    modport slave (
        input  busywait, jump, branch_eq, branch_ne, zero, offset,
        output pc, pc_plus4, target, fetch_valid, redirect_pending
`ifdef PC_WRAP_CHK_EN
        , output wrap_flag
`endif
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with stall hold and buffered redirect.
// Optional sticky wrap detection is enabled by defining PC_WRAP_CHK_EN.
module pc_sequencer #(
    parameter int              PC_W     = 32,
    parameter int              OFF_W    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        HOLD_REDIR = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [PC_W-1:0] saved, saved_n;
    logic            pending, pending_n;
    logic            fetch_valid, fetch_valid_n;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] target;
    logic            take;

    // Word offset: sign-extend to PC_W-2 bits, then scale to bytes.
    assign off_ext  = {{(PC_W-2-OFF_W){bus.offset[OFF_W-1]}}, bus.offset, 2'b00};
    assign pc_plus4 = pc + PC_W'(4);
    assign target   = pc_plus4 + off_ext;
    assign take     = bus.jump
                    | (bus.branch_eq & bus.zero)
                    | (bus.branch_ne & ~bus.zero);

`ifdef PC_WRAP_CHK_EN
    logic [PC_W:0]   p4_ext;
    logic [PC_W+1:0] tgt_ext;
    logic            p4_wrap, tgt_wrap;
    logic            wrap, wrap_hit;
    logic            saved_wrap, saved_wrap_n;

    // Widened copies of the adders expose carries out of / borrows below PC_W bits.
    assign p4_ext   = {1'b0, pc} + (PC_W+1)'(4);
    assign tgt_ext  = {2'b00, pc} + (PC_W+2)'(4)
                    + {{2{off_ext[PC_W-1]}}, off_ext};
    assign p4_wrap  = p4_ext[PC_W];
    assign tgt_wrap = |tgt_ext[PC_W+1:PC_W];
`endif

    // Next-state and next-register selection.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        saved_n       = saved;
        pending_n     = pending;
        fetch_valid_n = fetch_valid;
`ifdef PC_WRAP_CHK_EN
        wrap_hit      = 1'b0;
        saved_wrap_n  = saved_wrap;
`endif
        case (state)
            BOOT: begin
                state_n       = RUN;
                fetch_valid_n = 1'b1;
            end
            RUN: begin
                if (!bus.busywait) begin
                    pc_n = take ? target : pc_plus4;
`ifdef PC_WRAP_CHK_EN
                    wrap_hit = p4_wrap | (take & tgt_wrap);
`endif
                end else if (take) begin
                    saved_n   = target;
                    pending_n = 1'b1;
                    state_n   = HOLD_REDIR;
`ifdef PC_WRAP_CHK_EN
                    saved_wrap_n = p4_wrap | tgt_wrap;
`endif
                end
            end
            HOLD_REDIR: begin
                // The buffered target beats any redirect seen while waiting.
                if (!bus.busywait) begin
                    pc_n      = saved;
                    pending_n = 1'b0;
                    state_n   = RUN;
`ifdef PC_WRAP_CHK_EN
                    wrap_hit = saved_wrap;
`endif
                end
            end
            default: state_n = BOOT;
        endcase
    end

    // State and PC registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            saved       <= '0;
            pending     <= 1'b0;
            fetch_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            saved       <= saved_n;
            pending     <= pending_n;
            fetch_valid <= fetch_valid_n;
        end
    end

`ifdef PC_WRAP_CHK_EN
    // Sticky wrap flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap       <= 1'b0;
            saved_wrap <= 1'b0;
        end else begin
            wrap       <= wrap | wrap_hit;
            saved_wrap <= saved_wrap_n;
        end
    end

    assign bus.wrap_flag = wrap;
`endif

    assign bus.pc               = pc;
    assign bus.pc_plus4         = pc_plus4;
    assign bus.target           = target;
    assign bus.fetch_valid      = fetch_valid;
    assign bus.redirect_pending = pending;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: 32-bit instance for sequencing,
// 8-bit instance (RESET_PC=0xF0) for address wrap-around.
module tb_pc_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_sequencer_if #(.PC_W(32), .OFF_W(8)) bus32 ();
    pc_sequencer_if #(.PC_W(8),  .OFF_W(4)) bus8 ();

    pc_sequencer #(.PC_W(32), .OFF_W(8), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    pc_sequencer #(.PC_W(8), .OFF_W(4), .RESET_PC(8'hF0)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        bus32.busywait  = 1'b0;
        bus32.jump      = 1'b0;
        bus32.branch_eq = 1'b0;
        bus32.branch_ne = 1'b0;
        bus32.zero      = 1'b0;
        bus32.offset    = 8'h00;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        rst = 1'b1;
        step();
        checks++;
        if (bus32.pc !== 32'h0 || bus32.fetch_valid !== 1'b0
            || bus32.redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h fv=%b pend=%b exp 0/0/0",
                     bus32.pc, bus32.fetch_valid, bus32.redirect_pending);
        end
        rst = 1'b0;
        step();
        step();
        step();
        bus32.busywait = 1'b1;
        bus32.jump     = 1'b1;
        bus32.offset   = 8'h01;
        step();
        checks++;
        if (bus32.pc !== 32'h8 || bus32.redirect_pending !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pending pc=%h pend=%b exp 8/1",
                     bus32.pc, bus32.redirect_pending);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus32.pc !== 32'h0 || bus32.fetch_valid !== 1'b0
            || bus32.redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL async_reset pc=%h fv=%b pend=%b exp 0/0/0",
                     bus32.pc, bus32.fetch_valid, bus32.redirect_pending);
        end
        step();
        rst = 1'b0;
        clear_ctl();
        checks++;
        if (bus32.fetch_valid !== 1'b0 || bus32.pc !== 32'h0) begin
            errors++;
            $display("FAIL boot_state pc=%h fv=%b exp 0/0",
                     bus32.pc, bus32.fetch_valid);
        end
        step();
        checks++;
        if (bus32.fetch_valid !== 1'b1 || bus32.pc !== 32'h0) begin
            errors++;
            $display("FAIL boot_exit pc=%h fv=%b exp 0/1",
                     bus32.pc, bus32.fetch_valid);
        end
        exp_pc = 32'h0;
        for (int i = 0; i < 2; i++) begin
            step();
            exp_pc = exp_pc + 32'h4;
            checks++;
            if (bus32.pc !== exp_pc) begin
                errors++;
                $display("FAIL seq_pc%0d got %h exp %h", i, bus32.pc, exp_pc);
            end
        end
    endtask

    task automatic test_branch();
        step();
        step();
        checks++;
        if (bus32.pc !== 32'h10) begin
            errors++;
            $display("FAIL branch_setup got %h exp 10", bus32.pc);
        end
        bus32.branch_eq = 1'b1;
        bus32.zero      = 1'b1;
        bus32.offset    = 8'hFE;
        #1;
        checks++;
        if (bus32.pc_plus4 !== 32'h14 || bus32.target !== 32'h0C) begin
            errors++;
            $display("FAIL comb_adders p4=%h tgt=%h exp 14/0c",
                     bus32.pc_plus4, bus32.target);
        end
        step();
        checks++;
        if (bus32.pc !== 32'h0C) begin
            errors++;
            $display("FAIL beq_taken got %h exp 0c", bus32.pc);
        end
        bus32.branch_eq = 1'b0;
        step();
        bus32.branch_eq = 1'b1;
        bus32.zero      = 1'b0;
        step();
        checks++;
        if (bus32.pc !== 32'h14) begin
            errors++;
            $display("FAIL beq_not_taken got %h exp 14", bus32.pc);
        end
        bus32.branch_eq = 1'b0;
        bus32.branch_ne = 1'b1;
        step();
        checks++;
        if (bus32.pc !== 32'h10) begin
            errors++;
            $display("FAIL bne_taken got %h exp 10", bus32.pc);
        end
        bus32.zero = 1'b1;
        step();
        checks++;
        if (bus32.pc !== 32'h14) begin
            errors++;
            $display("FAIL bne_not_taken got %h exp 14", bus32.pc);
        end
        bus32.branch_eq = 1'b1;
        step();
        checks++;
        if (bus32.pc !== 32'h10) begin
            errors++;
            $display("FAIL beq_bne_or got %h exp 10", bus32.pc);
        end
        clear_ctl();
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (bus32.pc !== 32'h20) begin
            errors++;
            $display("FAIL redir_setup got %h exp 20", bus32.pc);
        end
        bus32.jump     = 1'b1;
        bus32.offset   = 8'h05;
        bus32.busywait = 1'b1;
        step();
        bus32.jump = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus32.pc !== 32'h20 || bus32.redirect_pending !== 1'b1) begin
                errors++;
                $display("FAIL redir_hold%0d pc=%h pend=%b exp 20/1",
                         i, bus32.pc, bus32.redirect_pending);
            end
            step();
        end
        bus32.jump   = 1'b1;
        bus32.offset = 8'h7F;
        step();
        checks++;
        if (bus32.pc !== 32'h20 || bus32.redirect_pending !== 1'b1) begin
            errors++;
            $display("FAIL redir_second_ignored pc=%h pend=%b exp 20/1",
                     bus32.pc, bus32.redirect_pending);
        end
        bus32.busywait = 1'b0;
        step();
        checks++;
        if (bus32.pc !== 32'h38 || bus32.redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL redir_release pc=%h pend=%b exp 38/0",
                     bus32.pc, bus32.redirect_pending);
        end
        clear_ctl();
    endtask

    task automatic test_stall();
        bus32.busywait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus32.pc !== 32'h38 || bus32.fetch_valid !== 1'b1
                || bus32.redirect_pending !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d pc=%h fv=%b pend=%b exp 38/1/0", i,
                         bus32.pc, bus32.fetch_valid, bus32.redirect_pending);
            end
        end
        bus32.busywait = 1'b0;
        step();
        checks++;
        if (bus32.pc !== 32'h3C) begin
            errors++;
            $display("FAIL stall_resume got %h exp 3c", bus32.pc);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc;
        rst = 1'b1;
        #1;
        checks++;
        if (bus8.pc !== 8'hF0) begin
            errors++;
            $display("FAIL wrap_reset_pc got %h exp f0", bus8.pc);
        end
        step();
        rst = 1'b0;
        step();
        exp_pc = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc = exp_pc + 8'h4;
            checks++;
            if (bus8.pc !== exp_pc) begin
                errors++;
                $display("FAIL wrap_seq%0d got %h exp %h", i, bus8.pc, exp_pc);
            end
        end
`ifdef PC_WRAP_CHK_EN
        checks++;
        if (bus8.wrap_flag !== 1'b0) begin
            errors++;
            $display("FAIL wrap_flag_pre got %b exp 0", bus8.wrap_flag);
        end
`endif
        step();
        checks++;
        if (bus8.pc !== 8'h00) begin
            errors++;
            $display("FAIL wrap_pc got %h exp 00", bus8.pc);
        end
`ifdef PC_WRAP_CHK_EN
        checks++;
        if (bus8.wrap_flag !== 1'b1) begin
            errors++;
            $display("FAIL wrap_flag_set got %b exp 1", bus8.wrap_flag);
        end
        step();
        step();
        checks++;
        if (bus8.wrap_flag !== 1'b1 || bus8.pc !== 8'h08) begin
            errors++;
            $display("FAIL wrap_flag_sticky flag=%b pc=%h exp 1/08",
                     bus8.wrap_flag, bus8.pc);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus8.wrap_flag !== 1'b0) begin
            errors++;
            $display("FAIL wrap_flag_reset got %b exp 0", bus8.wrap_flag);
        end
        step();
        rst = 1'b0;
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clear_ctl();
        bus8.busywait  = 1'b0;
        bus8.jump      = 1'b0;
        bus8.branch_eq = 1'b0;
        bus8.branch_ne = 1'b0;
        bus8.zero      = 1'b0;
        bus8.offset    = 4'h0;
        test_reset();
        test_branch();
        test_redirect();
        test_stall();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
